mem_ctrl: RTL and testbench

- Owns the single 8-bit unified RAM port and shares it between two requesters: instruction fetch (IF, word reads only) and the MEM stage (loads and stores of byte, half or word).
- Breaks each access into little-endian byte beats and assembles read data.
- Returns a one-cycle fin pulse to the granted requester.
- Sits between the pipeline and the RAM. The MEM stage's memctl_op/len/addr/data/fin/out bus connects directly to the mem_* ports.

---
 rtl/mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the single 8-bit RAM port between instruction fetch and the MEM stage
module mem_ctrl #(
  parameter int RAM_AW = 17,
  parameter int BEAT_W = 3
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              if_flush,
  output logic              if_fin,
  output logic [31:0]       if_out,
  input  logic [1:0]        mem_op,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_data,
  output logic              mem_fin,
  output logic [31:0]       mem_out,
  output logic [RAM_AW-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_is_if;
  logic [RAM_AW-1:0]   r_base;
  logic [BEAT_W-1:0]   r_n;
  logic [BEAT_W-1:0]   r_k;
  logic [BEAT_W-1:0]   r_j;
  logic                r_cv;
  logic [31:0]         r_wdata;
  logic [31:0]         r_asm;
  logic [RAM_AW-1:0]   r_a;
  logic                r_wr;
  logic [7:0]          r_dout;
  logic                w_mem_ld;
  logic                w_mem_st;
  logic                w_mem_go;
  logic                w_if_go;
  logic                w_grant;
  logic                w_flush;
  logic [BEAT_W-1:0]   w_n;
  logic [RAM_AW-1:0]   w_base;
  logic                w_unused;

  assign w_mem_ld = mem_op == 2'b01;
  assign w_mem_st = mem_op == 2'b10;
  assign w_mem_go = w_mem_ld | w_mem_st;
  assign w_if_go  = if_req & ~if_flush;
  assign w_grant  = (r_state == IDLE) & (w_mem_go | w_if_go);
  assign w_flush  = r_is_if & if_flush & ((r_state == RD) | (r_state == DONE));
  assign w_base   = w_mem_go ? mem_addr[RAM_AW-1:0] : if_addr[RAM_AW-1:0];
  assign w_n      = ~w_mem_go ? BEAT_W'(4) :
                    mem_len == 2'b00 ? BEAT_W'(1) :
                    mem_len == 2'b01 ? BEAT_W'(2) : BEAT_W'(4);
  assign w_unused = &{1'b0, if_addr[31:RAM_AW], mem_addr[31:RAM_AW]};

  // Address and write outputs are registered; a paused core never writes.
  assign ram_a    = r_a;
  assign ram_dout = r_dout;
  assign ram_wr   = r_wr & rdy_in;
  // Fin is routed to the granted requester only; a flush masks a pending IF fin.
  assign if_fin   = (r_state == DONE) & r_is_if & ~if_flush;
  assign mem_fin  = (r_state == DONE) & ~r_is_if;
  assign if_out   = r_asm;
  assign mem_out  = r_asm;

  // State register, frozen while the core is not ready.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= IDLE;
    else if (rdy_in) r_state <= w_next;
  end

  // Next state: MEM wins arbitration, reads finish after the last captured byte.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_mem_st ? WR : (w_mem_ld | w_if_go) ? RD : IDLE;
      RD:      w_next = w_flush ? IDLE : (r_cv && r_j == r_n - BEAT_W'(1)) ? DONE : RD;
      WR:      w_next = (r_k == r_n) ? DONE : WR;
      default: w_next = IDLE;
    endcase
  end

  // Datapath: latch the grant, issue byte beats, assemble little-endian read data.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_is_if <= 1'b0;
      r_base  <= '0;
      r_n     <= '0;
      r_k     <= '0;
      r_j     <= '0;
      r_cv    <= 1'b0;
      r_wdata <= '0;
      r_asm   <= '0;
      r_a     <= '0;
      r_wr    <= 1'b0;
      r_dout  <= '0;
    end else if (rdy_in) begin
      case (r_state)
        IDLE: begin
          r_wr <= 1'b0;
          if (w_grant) begin
            r_is_if <= ~w_mem_go;
            r_base  <= w_base;
            r_n     <= w_n;
            r_wdata <= mem_data;
            r_asm   <= '0;
            r_k     <= BEAT_W'(1);
            r_j     <= '0;
            r_cv    <= 1'b0;
            r_a     <= w_base;
            r_wr    <= w_mem_st;
            r_dout  <= mem_data[7:0];
          end
        end
        RD: begin
          r_cv <= 1'b1;
          if (r_k < r_n) begin
            r_a <= r_base + RAM_AW'(r_k);
            r_k <= r_k + BEAT_W'(1);
          end
          if (r_cv) begin
            r_asm[8*r_j[1:0] +: 8] <= ram_din;
            r_j <= r_j + BEAT_W'(1);
          end
        end
        WR: begin
          if (r_k < r_n) begin
            r_a    <= r_base + RAM_AW'(r_k);
            r_dout <= r_wdata[8*r_k[1:0] +: 8];
            r_k    <= r_k + BEAT_W'(1);
          end else begin
            r_wr <= 1'b0;
          end
        end
        default: r_wr <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scoreboard bench for the RAM port arbiter
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_fin;
  logic [31:0] if_out;
  logic [1:0]  mem_op = '0;
  logic [1:0]  mem_len = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        mem_fin;
  logic [31:0] mem_out;
  logic [16:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;

  logic        tb_we = 1'b0;
  logic [16:0] tb_wa = '0;
  logic [7:0]  tb_wd = '0;
  logic [7:0]  ram [0:(1<<17)-1];

  int cyc = 0;
  int wr_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        is_if;
    logic        chk_data;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_fin(if_fin), .if_out(if_out),
    .mem_op(mem_op), .mem_len(mem_len), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_fin(mem_fin), .mem_out(mem_out),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Synchronous byte RAM, paused together with the core; tb_we preloads it.
  always @(posedge clk_in) begin
    if (tb_we) ram[tb_wa] <= tb_wd;
    else if (rdy_in) begin
      if (ram_wr) ram[ram_a] <= ram_dout;
      ram_din <= ram[ram_a];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: every fin pops the scoreboard and is checked for requester, timing and data.
  always @(negedge clk_in) begin
    if (ram_wr) wr_cnt <= wr_cnt + 1;
    if (if_fin || mem_fin) begin
      chk("dual_fin", {31'b0, if_fin & mem_fin}, 32'd0);
      chk("sb_nonempty", {31'b0, q.size() > 0}, 32'd1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("fin_who", {31'b0, if_fin}, {31'b0, e.is_if});
        chk("fin_cycle", cyc, e.cyc);
        if (e.chk_data) chk("fin_data", e.is_if ? if_out : mem_out, e.data);
      end
    end
  end

  task automatic poke(input logic [16:0] a, input logic [7:0] d);
    tb_wa = a;
    tb_wd = d;
    tb_we = 1'b1;
    @(posedge clk_in);
    #1 tb_we = 1'b0;
  endtask

  task automatic push(input logic is_if, input logic chk_data, input logic [31:0] data, input int c);
    exp_t e;
    e.is_if = is_if;
    e.chk_data = chk_data;
    e.data = data;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic wait_fin(input int bound);
    logic got;
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk_in);
      if (if_fin || mem_fin) got = 1'b1;
    end
    chk("fin_timeout", {31'b0, got}, 32'd1);
  endtask

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    int c0;
    int w0;
    poke(17'h00100, 8'h11); poke(17'h00101, 8'h22);
    poke(17'h00102, 8'h33); poke(17'h00103, 8'h44);
    poke(17'h00200, 8'hA5);
    poke(17'h00300, 8'h01); poke(17'h00301, 8'h02);
    poke(17'h00302, 8'h03); poke(17'h00303, 8'h04);
    poke(17'h00000, 8'h5A); poke(17'h00001, 8'h77);
    poke(17'h00002, 8'h88); poke(17'h00003, 8'h99);
    poke(17'h1FFFE, 8'h66); poke(17'h1FFFF, 8'h00);
    poke(17'h00400, 8'h00); poke(17'h00401, 8'h00); poke(17'h00402, 8'h00);
    chk("rst_ram_a", {15'b0, ram_a}, 32'd0);
    chk("rst_ram_wr", {31'b0, ram_wr}, 32'd0);
    chk("rst_ram_dout", {24'b0, ram_dout}, 32'd0);
    chk("rst_fins", {30'b0, if_fin, mem_fin}, 32'd0);
    chk("rst_if_out", if_out, 32'd0);
    chk("rst_mem_out", mem_out, 32'd0);
    next_cycle();
    rst_in = 1'b1;
    repeat (2) next_cycle();

    // Word load with address stepping.
    mem_op = 2'b01; mem_len = 2'b10; mem_addr = 32'h100;
    c0 = cyc;
    push(1'b0, 1'b1, 32'h44332211, c0 + 6);
    @(posedge clk_in);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk("load_ram_a", {15'b0, ram_a}, 32'h100 + k);
      @(posedge clk_in);
    end
    wait_fin(10);
    next_cycle();
    mem_op = 2'b00;
    repeat (2) next_cycle();

    // Half store wrapping the top of the address space.
    w0 = wr_cnt;
    mem_op = 2'b10; mem_len = 2'b01; mem_addr = 32'h1FFFF; mem_data = 32'hAABBCCDD;
    c0 = cyc;
    push(1'b0, 1'b0, 32'h0, c0 + 3);
    wait_fin(10);
    next_cycle();
    mem_op = 2'b00;
    chk("st_wr_cycles", wr_cnt - w0, 32'd2);
    chk("st_byte0", {24'b0, ram[17'h1FFFF]}, 32'hDD);
    chk("st_byte1", {24'b0, ram[17'h00000]}, 32'hCC);
    chk("st_keep_hi", {24'b0, ram[17'h1FFFE]}, 32'h66);
    chk("st_keep_lo", {24'b0, ram[17'h00001]}, 32'h77);
    repeat (2) next_cycle();

    // Contention: MEM byte load wins, IF word fetch follows.
    mem_op = 2'b01; mem_len = 2'b00; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h300;
    c0 = cyc;
    push(1'b0, 1'b1, 32'h000000A5, c0 + 3);
    push(1'b1, 1'b1, 32'h04030201, c0 + 10);
    wait_fin(10);
    next_cycle();
    mem_op = 2'b00;
    wait_fin(12);
    next_cycle();
    if_req = 1'b0;
    repeat (2) next_cycle();

    // Held request: exactly one extra access after DONE.
    mem_op = 2'b01; mem_len = 2'b00; mem_addr = 32'h200;
    c0 = cyc;
    push(1'b0, 1'b1, 32'h000000A5, c0 + 3);
    push(1'b0, 1'b1, 32'h000000A5, c0 + 7);
    wait_fin(10);
    next_cycle();
    next_cycle();
    mem_op = 2'b00;
    wait_fin(10);
    repeat (8) next_cycle();
    chk("held_sb_empty", q.size(), 32'd0);

    // Flush on the third RD cycle, then a clean fetch from 0x0.
    if_req = 1'b1; if_addr = 32'h300;
    repeat (3) next_cycle();
    if_flush = 1'b1;
    #1 chk("flush_mask", {31'b0, if_fin}, 32'd0);
    next_cycle();
    if_flush = 1'b0; if_req = 1'b0;
    repeat (8) next_cycle();
    if_req = 1'b1; if_addr = 32'h0;
    c0 = cyc;
    push(1'b1, 1'b1, 32'h998877CC, c0 + 6);
    wait_fin(12);
    next_cycle();
    if_req = 1'b0;
    repeat (2) next_cycle();

    // Three-cycle pause mid word load.
    mem_op = 2'b01; mem_len = 2'b10; mem_addr = 32'h100;
    c0 = cyc;
    push(1'b0, 1'b1, 32'h44332211, c0 + 9);
    repeat (2) next_cycle();
    rdy_in = 1'b0;
    repeat (3) next_cycle();
    rdy_in = 1'b1;
    wait_fin(12);
    next_cycle();
    mem_op = 2'b00;
    repeat (2) next_cycle();

    // Reset in the middle of a word store.
    mem_op = 2'b10; mem_len = 2'b10; mem_addr = 32'h400; mem_data = 32'hDEADBEEF;
    repeat (2) next_cycle();
    chk("pre_rst_wr", {31'b0, ram_wr}, 32'd1);
    rst_in = 1'b0;
    mem_op = 2'b00;
    #1;
    chk("rst_mid_wr", {31'b0, ram_wr}, 32'd0);
    chk("rst_mid_fin", {30'b0, if_fin, mem_fin}, 32'd0);
    chk("rst_mid_a", {15'b0, ram_a}, 32'd0);
    next_cycle();
    rst_in = 1'b1;
    repeat (10) next_cycle();
    chk("rst_byte0", {24'b0, ram[17'h00400]}, 32'hEF);
    chk("rst_byte1", {24'b0, ram[17'h00401]}, 32'h00);
    chk("end_sb_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
